// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR datapath widths and output buffering defaults
package fir_pkg;
    localparam int FirInWidth   = 38;
    localparam int FirOutWidth  = 16;
    localparam int FirFracShift = 15;
    localparam int FirOutDepth  = 8;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through FIFO with occupancy count
module sync_fifo #(
    parameter int Width = 16,
    parameter int Depth = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [Width-1:0]       wdata,
    input  logic                   pop,
    output logic [Width-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] level
);
    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(Depth));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/fir_out_quantizer.sv
// rtl/fir_out_quantizer.sv - round, saturate and buffer FIR accumulator results
module fir_out_quantizer
    import fir_pkg::*;
#(
    parameter int InWidth   = FirInWidth,
    parameter int OutWidth  = FirOutWidth,
    parameter int FracShift = FirFracShift,
    parameter int Depth     = FirOutDepth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inValid,
    input  logic [InWidth-1:0]     din,
    input  logic                   clrFlags,
    input  logic                   outReady,
    output logic                   outValid,
    output logic [OutWidth-1:0]    dout,
    output logic [$clog2(Depth):0] level,
    output logic                   satFlag,
    output logic                   overflow
);
    localparam logic signed [InWidth:0] Half =
        {{(InWidth + 1 - FracShift){1'b0}}, 1'b1, {(FracShift - 1){1'b0}}};
    localparam logic signed [InWidth:0] QMax =
        {{(InWidth + 2 - OutWidth){1'b0}}, {(OutWidth - 1){1'b1}}};
    localparam logic signed [InWidth:0] QMin =
        {{(InWidth + 2 - OutWidth){1'b1}}, {(OutWidth - 1){1'b0}}};

    logic signed [InWidth:0] sum;
    logic signed [InWidth:0] q;
    logic [OutWidth-1:0]     q_sat;
    logic                    q_clamped;
    logic                    s1_valid;
    logic [OutWidth-1:0]     s1_data;
    logic                    s1_sat;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    drop;

    // One extra bit keeps the rounding add from wrapping at the positive limit.
    always_comb begin
        sum       = $signed({din[InWidth-1], din}) + Half;
        q         = sum >>> FracShift;
        q_sat     = q[OutWidth-1:0];
        q_clamped = 1'b0;
        if (q > QMax) begin
            q_sat     = QMax[OutWidth-1:0];
            q_clamped = 1'b1;
        end else if (q < QMin) begin
            q_sat     = QMin[OutWidth-1:0];
            q_clamped = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_sat   <= 1'b0;
        end else begin
            s1_valid <= inValid;
            s1_data  <= q_sat;
            s1_sat   <= q_clamped;
        end
    end

    sync_fifo #(
        .Width (OutWidth),
        .Depth (Depth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (s1_valid),
        .wdata (s1_data),
        .pop   (outReady),
        .rdata (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign outValid = !fifo_empty;
    assign drop     = s1_valid && fifo_full && !(outValid && outReady);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            satFlag  <= 1'b0;
            overflow <= 1'b0;
        end else if (clrFlags) begin
            satFlag  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (s1_valid && s1_sat && !drop) begin
                satFlag <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_out_quantizer.sv
// tb/tb_fir_out_quantizer.sv - directed self-checking bench for fir_out_quantizer
module tb_fir_out_quantizer;
    logic        clk;
    logic        rst;
    logic        inValid;
    logic [37:0] din;
    logic        clrFlags;
    logic        outReady;
    logic        outValid;
    logic [15:0] dout;
    logic [3:0]  level;
    logic        satFlag;
    logic        overflow;

    int n_assert = 0;
    int n_fail   = 0;

    fir_out_quantizer dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .din      (din),
        .clrFlags (clrFlags),
        .outReady (outReady),
        .outValid (outValid),
        .dout     (dout),
        .level    (level),
        .satFlag  (satFlag),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_chk(input logic [37:0] v, input logic signed [63:0] exp, input string tag);
        din     = v;
        inValid = 1'b1;
        tick;
        inValid = 1'b0;
        chk({tag, "_valid_k"}, outValid, 0);
        tick;
        chk({tag, "_valid_k1"}, outValid, 1);
        chk({tag, "_dout"}, $signed(dout), exp);
        tick;
        chk({tag, "_popped"}, outValid, 0);
    endtask

    initial begin
        rst = 1'b0; inValid = 1'b0; din = '0; clrFlags = 1'b0; outReady = 1'b0;
        #2;
        chk("rst_valid", outValid, 0);
        chk("rst_level", level, 0);
        chk("rst_dout", dout, 0);
        chk("rst_sat", satFlag, 0);
        chk("rst_ovf", overflow, 0);
        tick;
        rst = 1'b1;
        tick;

        outReady = 1'b1;
        send_chk(38'd3276800, 100, "basic");
        chk("basic_sat", satFlag, 0);

        send_chk(38'd16384, 1, "rnd_p16384");
        send_chk(38'd16383, 0, "rnd_p16383");
        send_chk(-38'sd16384, 0, "rnd_m16384");
        send_chk(-38'sd16385, -1, "rnd_m16385");
        chk("rnd_sat", satFlag, 0);

        send_chk(38'h1F_FFFF_FFFF, 32767, "sat_pos");
        chk("sat_pos_flag", satFlag, 1);
        send_chk(38'h20_0000_0000, -32768, "sat_neg");
        clrFlags = 1'b1;
        tick;
        clrFlags = 1'b0;
        chk("sat_clear", satFlag, 0);

        outReady = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            din = 38'(i) << 15;
            inValid = 1'b1;
            tick;
        end
        inValid = 1'b0;
        tick;
        chk("ovf_level", level, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_sat", satFlag, 0);
        outReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_drain", $signed(dout), i);
            tick;
        end
        chk("ovf_empty", outValid, 0);
        outReady = 1'b0;
        clrFlags = 1'b1;
        tick;
        clrFlags = 1'b0;
        chk("ovf_clear", overflow, 0);

        for (int i = 1; i <= 8; i++) begin
            din = 38'(i) << 15;
            inValid = 1'b1;
            tick;
        end
        inValid = 1'b0;
        tick;
        chk("pp_full", level, 8);
        din = 38'd99 << 15;
        inValid = 1'b1;
        tick;
        inValid = 1'b0;
        outReady = 1'b1;
        tick;
        outReady = 1'b0;
        chk("pp_level", level, 8);
        chk("pp_ovf", overflow, 0);
        chk("pp_head", $signed(dout), 2);
        tick;
        chk("pp_hold", $signed(dout), 2);
        outReady = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            chk("pp_drain", $signed(dout), i);
            tick;
        end
        chk("pp_last", $signed(dout), 99);
        tick;
        chk("pp_empty", outValid, 0);

        outReady = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            din = 38'(i) << 15;
            inValid = 1'b1;
            tick;
        end
        chk("mid_level", level, 5);
        rst = 1'b0;
        inValid = 1'b0;
        #1;
        chk("mid_rst_valid", outValid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_dout", dout, 0);
        tick;
        rst = 1'b1;
        tick;
        chk("post_rst_level", level, 0);
        outReady = 1'b1;
        send_chk(38'd42 << 15, 42, "post_rst");
        chk("post_rst_ovf", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
